// File: rtl/tx_unit.sv
// tx_unit: 11-bit UART-style serial transmitter.
// Frame = start, 8 data bits LSB first, parity (or 1), stop.
module tx_unit #(
  parameter logic [15:0] DIV_2400  = 16'd41667,
  parameter logic [15:0] DIV_4800  = 16'd20833,
  parameter logic [15:0] DIV_9600  = 16'd10417,
  parameter logic [15:0] DIV_19200 = 16'd5208
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  par_q, par_d;
  logic [1:0]  baud_q, baud_d;
  logic        tx_q, tx_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  logic [15:0] div;
  logic        par_bit;
  logic        last;

  always_comb begin
    div = DIV_2400;
    case (baud_q)
      2'b00:   div = DIV_2400;
      2'b01:   div = DIV_4800;
      2'b10:   div = DIV_9600;
      default: div = DIV_19200;
    endcase
  end

  always_comb begin
    par_bit = 1'b1;
    if (par_q == 2'b01) begin
      par_bit = ~^data_q;
    end else if (par_q == 2'b10) begin
      par_bit = ^data_q;
    end
  end

  assign last = (cnt_q == div - 16'd1);

  // tx_d is the value of the bit that starts on the coming edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    baud_d   = baud_q;
    tx_d     = tx_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      tx_d     = 1'b1;
      active_d = 1'b0;
      if (send) begin
        data_d   = data_in;
        par_d    = parity_type;
        baud_d   = baud_rate;
        state_d  = START;
        cnt_d    = 16'd0;
        idx_d    = 3'd0;
        tx_d     = 1'b0;
        active_d = 1'b1;
      end
    end else if (!last) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
        DATA: begin
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q+3'd1];
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          state_d  = IDLE;
          tx_d     = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
        default: begin
          state_d  = IDLE;
          tx_d     = 1'b1;
          active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      data_q   <= 8'd0;
      par_q    <= 2'd0;
      baud_q   <= 2'd0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: doc/tx_unit.md
TX_UNIT -- requirements
Module: tx_unit

Interface
REQ-001 SHALL have port: clock  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: send  input  1  transmit request, sampled on rising edge of clock.
REQ-004 SHALL have port: data_in  input  8  byte to transmit.
REQ-005 SHALL have port: parity_type  input  2  parity mode: 01 odd, 10 even, 00/11 no parity.
REQ-006 SHALL have port: baud_rate  input  2  rate select: 00 2400, 01 4800, 10 9600, 11 19200.
REQ-007 SHALL have port: data_tx  output  1  serial line, idle high.
REQ-008 SHALL have port: active_flag  output  1  high while a frame is in flight.
REQ-009 SHALL have port: done_flag  output  1  one-cycle pulse on frame completion.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL emit a fixed 11-bit frame, in this order:
- start bit = 0;
- data_in[0] through data_in[7], LSB first;
- parity bit;
- stop bit = 1.
REQ-012 SHALL compute the parity bit as follows:
- odd mode: ~^data;
- even mode: ^data;
- no-parity modes: constant 1 in the parity slot, so the frame length stays 11 bits.
REQ-013 SHALL hold each bit for exactly DIV clocks: 00 -> 41667, 01 -> 20833, 10 -> 10417, 11 -> 5208.
REQ-014 SHALL use a 16-bit bit-period counter that counts 0..DIV-1, restarts at each bit boundary and never wraps mid-bit.
REQ-015 SHALL accept send only in IDLE, and SHALL latch data_in, parity_type and baud_rate on the accepting edge.
REQ-016 SHALL ignore input changes after acceptance until the next accept.
REQ-017 SHALL ignore send while in START, DATA, PARITY or STOP; the request is dropped, not queued.
REQ-018 SHALL drive data_tx low on the rising edge of clock following the accepting edge (latency 1 clock).
REQ-019 SHALL drive active_flag high from that same edge through the last clock of the stop bit.
REQ-020 SHALL sequence states as follows:
- IDLE -> START on accepted send;
- START -> DATA after DIV clocks;
- DATA -> PARITY after 8 bit periods, using a 3-bit index 0..7;
- PARITY -> STOP after DIV clocks;
- STOP -> IDLE after DIV clocks.
REQ-021 SHALL assert done_flag for exactly one clock, on the first IDLE cycle after STOP; active_flag SHALL be low in that cycle.
REQ-022 SHALL accept a send asserted during the done_flag cycle, giving back-to-back frames with exactly DIV stop-bit clocks plus 1 idle clock between frames.
REQ-023 SHALL hold data_tx high whenever in IDLE.
REQ-024 SHALL drive data_tx from a register (glitch-free, no combinational path from inputs).
REQ-025 SHALL make a send held high continuously start a new frame each time IDLE is reached.

Reset
REQ-026 SHALL, while reset_n is low, force the following regardless of clock:
- state IDLE;
- data_tx = 1;
- active_flag = 0;
- done_flag = 0;
- counters = 0;
- latched data/config = 0.
REQ-027 SHALL, when reset is asserted mid-frame, abort the frame immediately with data_tx = 1 and no done_flag pulse.
REQ-028 SHALL accept the first send no earlier than the first rising edge after reset_n deasserts.

Verification
REQ-029 Bench SHALL cover: baud_rate=10, parity_type=01, send data_in=8'h95 -> data_tx sequence 0,1,0,1,0,1,0,0,1,1,1, each 10417 clocks; done_flag pulses once at 114588 clocks after accept.
REQ-030 Bench SHALL cover: baud_rate=11, parity_type=10, data_in=8'hCC -> parity bit 0, bit period 5208 clocks, frame length 57288 clocks.
REQ-031 Bench SHALL cover: parity_type=00, data_in=8'h01 -> parity slot transmits 1; frame remains 11 bits.
REQ-032 Bench SHALL cover: send pulsed again mid-DATA with different data_in -> current frame unchanged, no second frame, single done_flag.
REQ-033 Bench SHALL cover: send held high for two frames (data_in=8'hA5, baud_rate=11) -> second start bit begins exactly 1 clock after the first done_flag; two done_flag pulses.
REQ-034 Bench SHALL cover: reset_n driven low during bit 4 of DATA -> data_tx=1 and active_flag=0 asynchronously, no done_flag pulse; after release, next send produces a complete, correct frame.
